// File: rtl/k_energy_accumulator_if.sv
// Stream bundle for k_energy_accumulator: complex-bin input stream and the
// held frame-energy result stream. The accumulator uses the slave modport;
// the producer/consumer side uses the master modport.
interface k_energy_accumulator_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 40
);
    logic signed [IN_WIDTH-1:0]  in_re;
    logic signed [IN_WIDTH-1:0]  in_im;
    logic                        in_valid;
    logic                        in_ready;
    logic        [OUT_WIDTH-1:0] out_energy;
    logic                        out_sat;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  in_re, in_im, in_valid, out_ready,
        output in_ready, out_energy, out_sat, out_valid
    );

    modport master (
        output in_re, in_im, in_valid, out_ready,
        input  in_ready, out_energy, out_sat, out_valid
    );
endinterface

// File: rtl/k_energy_accumulator.sv
// Frame energy accumulator: per-bin re^2+im^2 over a pipeline, summed over
// FRAME_LEN bins and presented as a held valid/ready result.
// Optional macro K_ENERGY_ACC_SAT_EN: saturating accumulator with sticky
// out_sat; when undefined the accumulator wraps and out_sat stays 0.
//
// state | meaning
// IDLE  | acc and count cleared, waiting for the first bin of a frame
// ACCUM | accepting bins, count tracks bins taken so far
// FLUSH | three cycles letting the last bins drain into acc
// HOLD  | frame result held on the output until out_ready
module k_energy_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 40,
    parameter int FRAME_LEN = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    k_energy_accumulator_if.slave  bus
);

    localparam int PW = 2 * IN_WIDTH;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;

    state_t state, state_next;

    logic [CW-1:0]        count;
    logic [1:0]           flush_cnt;
    logic                 in_ready;
    logic                 accept;
    logic                 load_out;
    logic                 release_out;

    logic                 v1, v2;
    logic [PW-1:0]        re_sq, im_sq;
    logic [PW:0]          sum_q;
    logic [OUT_WIDTH-1:0] sum_ext;
    logic [OUT_WIDTH-1:0] acc, acc_next;
    logic                 sat_acc, sat_next;

    logic [OUT_WIDTH-1:0] energy_q;
    logic                 sat_q;
    logic                 valid_q;

    logic signed [PW-1:0] re_x, im_x;

    // Sign-extend before squaring so the product is formed at full width.
    assign re_x = PW'(bus.in_re);
    assign im_x = PW'(bus.in_im);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; the accept that takes the last bin of the frame goes
    // straight to FLUSH (from IDLE too when a frame is a single bin).
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: if (accept) state_next = (count == LAST) ? FLUSH : ACCUM;
            FLUSH:       if (flush_cnt == 2'd2) state_next = HOLD;
            HOLD:        if (valid_q && bus.out_ready) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Output/strobe decode from the state register.
    always_comb begin
        in_ready    = !rst && (state == IDLE || state == ACCUM);
        accept      = bus.in_valid && in_ready;
        load_out    = (state == FLUSH) && (flush_cnt == 2'd2);
        release_out = (state == HOLD) && valid_q && bus.out_ready;
    end

    // Bin counter and flush timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            flush_cnt <= 2'd0;
        end else begin
            if (accept) count <= (count == LAST) ? '0 : count + 1'b1;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
        end
    end

    // Square and sum pipeline, with a valid bit riding along each stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            re_sq <= '0;
            im_sq <= '0;
            sum_q <= '0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            if (accept) begin
                re_sq <= $unsigned(re_x * re_x);
                im_sq <= $unsigned(im_x * im_x);
            end
            if (v1) sum_q <= {1'b0, re_sq} + {1'b0, im_sq};
        end
    end

    assign sum_ext = OUT_WIDTH'(sum_q);

`ifdef K_ENERGY_ACC_SAT_EN
    logic [OUT_WIDTH:0] acc_sum;

    // Saturating add; clipping marks the frame for the rest of its life.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, sum_ext};
        if (acc_sum[OUT_WIDTH]) begin
            acc_next = '1;
            sat_next = 1'b1;
        end else begin
            acc_next = acc_sum[OUT_WIDTH-1:0];
            sat_next = sat_acc;
        end
    end
`else
    // Wrapping add; no clip indication.
    always_comb begin
        acc_next = acc + sum_ext;
        sat_next = 1'b0;
    end
`endif

    // Accumulator, cleared when the held result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sat_acc <= 1'b0;
        end else if (release_out) begin
            acc     <= '0;
            sat_acc <= 1'b0;
        end else if (v2) begin
            acc     <= acc_next;
            sat_acc <= sat_next;
        end
    end

    // Result register: loaded at the end of FLUSH, held through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            energy_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else if (load_out) begin
            energy_q <= acc;
            sat_q    <= sat_acc;
            valid_q  <= 1'b1;
        end else if (release_out) begin
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_energy = energy_q;
    assign bus.out_sat    = sat_q;
    assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_k_energy_accumulator.sv
// Directed bench for k_energy_accumulator: three instances (4-bin frames at
// 40 and 33 output bits sharing one stimulus, and 1-bin frames).
module tb_k_energy_accumulator;

    logic clk;
    logic rst;
    logic signed [15:0] re, im;
    logic valid4, valid1, ready4, ready1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc4   = 0;
    int n0;

    k_energy_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(40)) bus4 ();
    k_energy_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(33)) bus_s ();
    k_energy_accumulator_if #(.IN_WIDTH(16), .OUT_WIDTH(40)) bus1 ();

    assign bus4.in_re     = re;
    assign bus4.in_im     = im;
    assign bus4.in_valid  = valid4;
    assign bus4.out_ready = ready4;
    assign bus_s.in_re     = re;
    assign bus_s.in_im     = im;
    assign bus_s.in_valid  = valid4;
    assign bus_s.out_ready = ready4;
    assign bus1.in_re     = re;
    assign bus1.in_im     = im;
    assign bus1.in_valid  = valid1;
    assign bus1.out_ready = ready1;

    k_energy_accumulator #(.IN_WIDTH(16), .OUT_WIDTH(40), .FRAME_LEN(4))
        u_f4 (.clk(clk), .rst(rst), .bus(bus4));
    k_energy_accumulator #(.IN_WIDTH(16), .OUT_WIDTH(33), .FRAME_LEN(4))
        u_sat (.clk(clk), .rst(rst), .bus(bus_s));
    k_energy_accumulator #(.IN_WIDTH(16), .OUT_WIDTH(40), .FRAME_LEN(1))
        u_f1 (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (bus4.in_valid && bus4.in_ready) n_acc4++;

`ifdef K_ENERGY_ACC_SAT_EN
    localparam logic [63:0] SAT_E = 64'd8589934591;
    localparam logic [63:0] SAT_F = 64'd1;
`else
    localparam logic [63:0] SAT_E = 64'd0;
    localparam logic [63:0] SAT_F = 64'd0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send4(input int r, input int i);
        re = r[15:0];
        im = i[15:0];
        valid4 = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_ready4();
        ready4 = 1'b1;
        @(negedge clk);
        ready4 = 1'b0;
    endtask

    // Called at the negedge after the last accept E0: result must appear after E3.
    task automatic expect_frame4(input string tag, input logic [63:0] e4);
        chk({tag, "_busy_ready"}, bus4.in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early_valid"}, bus4.out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, bus4.out_valid, 1);
        chk({tag, "_energy"}, bus4.out_energy, e4);
        chk({tag, "_sat"}, bus4.out_sat, 0);
    endtask

    initial begin
        rst = 1'b1; re = '0; im = '0;
        valid4 = 1'b0; valid1 = 1'b0; ready4 = 1'b0; ready1 = 1'b0;

        #12;
        chk("rst_in_ready", bus4.in_ready, 0);
        chk("rst_out_valid", bus4.out_valid, 0);
        chk("rst_out_energy", bus4.out_energy, 0);
        chk("rst_out_sat", bus4.out_sat, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus4.in_ready, 1);

        // Basic frame, back-to-back.
        n0 = n_acc4;
        send4(3, 4); send4(1, -1); send4(0, 0); send4(-2, 0);
        valid4 = 1'b0;
        expect_frame4("basic", 64'd31);
        chk("basic_sat_inst_energy", bus_s.out_energy, 31);
        chk("basic_sat_inst_sat", bus_s.out_sat, 0);
        chk("basic_accepts", n_acc4 - n0, 4);

        // Back-pressure: result held while out_ready is low.
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", bus4.out_valid, 1);
            chk("bp_energy", bus4.out_energy, 31);
            chk("bp_in_ready", bus4.in_ready, 0);
        end
        pulse_ready4();
        chk("bp_release_valid", bus4.out_valid, 0);
        chk("bp_release_in_ready", bus4.in_ready, 1);

        // out_ready held high throughout a frame has no early effect.
        ready4 = 1'b1;
        repeat (4) send4(1, 0);
        valid4 = 1'b0;
        expect_frame4("ones", 64'd4);
        @(negedge clk);
        chk("ones_auto_release", bus4.out_valid, 0);
        ready4 = 1'b0;

        // Gaps of two idle cycles between bins.
        n0 = n_acc4;
        send4(3, 4);  valid4 = 1'b0; repeat (2) @(negedge clk);
        send4(1, -1); valid4 = 1'b0; repeat (2) @(negedge clk);
        send4(0, 0);  valid4 = 1'b0; repeat (2) @(negedge clk);
        send4(-2, 0); valid4 = 1'b0;
        expect_frame4("gaps", 64'd31);
        chk("gaps_accepts", n_acc4 - n0, 4);
        pulse_ready4();

        // Most negative inputs: each bin 2^31, frame total 2^33.
        repeat (4) send4(-32768, -32768);
        valid4 = 1'b0;
        expect_frame4("big40", 64'd8589934592);
        chk("sat33_energy", bus_s.out_energy, SAT_E);
        chk("sat33_flag", bus_s.out_sat, SAT_F);
        pulse_ready4();

        // Asynchronous reset in the middle of a frame.
        send4(5, 5); send4(5, 5);
        valid4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", bus4.in_ready, 0);
        chk("midrst_out_energy", bus4.out_energy, 0);
        chk("midrst_out_valid", bus4.out_valid, 0);
        chk("midrst_sat_inst_energy", bus_s.out_energy, 0);
        chk("midrst_f1_in_ready", bus1.in_ready, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        repeat (4) send4(1, 0);
        valid4 = 1'b0;
        expect_frame4("after_rst", 64'd4);
        pulse_ready4();

        // Single-bin frames.
        re = 16'sd2; im = 16'sd3; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        chk("f1_busy_ready", bus1.in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("f1a_early_valid", bus1.out_valid, 0);
        @(negedge clk);
        chk("f1a_valid", bus1.out_valid, 1);
        chk("f1a_energy", bus1.out_energy, 13);
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        chk("f1_release_valid", bus1.out_valid, 0);
        chk("f1_release_ready", bus1.in_ready, 1);
        re = 16'sd0; im = 16'sd1; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("f1b_early_valid", bus1.out_valid, 0);
        @(negedge clk);
        chk("f1b_valid", bus1.out_valid, 1);
        chk("f1b_energy", bus1.out_energy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k_energy_accumulator.md
# k_energy_accumulator

Streaming frame-energy block for the audio compressor datapath. Accepts complex FFT bins over a valid/ready handshake and computes the per-bin energy re²+im² in a two-stage pipeline. Accumulates the energies over a frame of FRAME_LEN bins and presents the frame total on a held valid/ready output. Sits between the FFT output stream and the compressor gain computer, and replaces the single-bin energy computer where per-frame energy is needed.

## Interface
- IN_WIDTH, 16: signed width of each of in_re and in_im.
- OUT_WIDTH, 40: unsigned accumulator and output width. Must be ≥ 2*IN_WIDTH+1.
- FRAME_LEN, 1024: bins per frame. Must be ≥ 1. The counter width is clog2(FRAME_LEN) (minimum 1).
- clk  in  1  Single clock. All logic is rising-edge.
- rst  in  1  Asynchronous, active-high reset.
- in_re  in  IN_WIDTH  Signed real part.
- in_im  in  IN_WIDTH  Signed imaginary part.
- in_valid  in  1  Input sample present.
- in_ready  out  1  Block can accept a sample.
- out_energy  out  OUT_WIDTH  Frame energy. Unsigned.
- out_sat  out  1  The accumulator clipped during this frame. Qualified by out_valid.
- out_valid  out  1  Frame result present.
- out_ready  in  1  Downstream accepts the result.

## Operation
- Accept rule: a sample is accepted on a rising edge where in_valid && in_ready.
- Stage 1 (accept edge): register re_sq = in_re*in_re and im_sq = in_im*in_im as signed products, stored as 2*IN_WIDTH-bit unsigned. (-2^(IN_WIDTH-1))² fits.
- Stage 2: sum = re_sq + im_sq, 2*IN_WIDTH+1 bits, zero-extended to OUT_WIDTH.
- Stage 3: acc <= acc + sum.
- A valid bit travels with each stage. Only valid data updates acc.
- FSM states:
  - IDLE: acc = 0, count = 0. First accept → ACCUM. If FRAME_LEN == 1, first accept → FLUSH.
  - ACCUM: each accept increments count. The accept that makes count reach FRAME_LEN → FLUSH.
  - FLUSH: fixed 3 cycles while the pipeline drains. On the 3rd edge, out_energy <= final acc value (including the last bin), out_valid <= 1, → HOLD.
  - HOLD: out_energy, out_sat and out_valid are held stable. On the edge with out_valid && out_ready: out_valid <= 0, acc and out_sat cleared, → IDLE.
- in_ready = !rst && (state == IDLE || state == ACCUM). It is combinational from the state register.
- Gaps in in_valid are allowed at any point in a frame. They do not alter the result.

## Timing
- Reset values: out_energy = 0, out_sat = 0, out_valid = 0, in_ready = 0 while rst is high. State = IDLE, acc = 0, count = 0, pipeline valid bits = 0.
- in_ready = 1 in the first cycle after rst deasserts.
- Latency: with the last bin accepted at edge E0, out_valid is high after edge E3. in_ready is low from after E0 until the block returns to IDLE.
- Minimum frame period: FRAME_LEN + 4 cycles (accepts, 3 FLUSH cycles, 1 HOLD cycle with out_ready high).
- out_ready high while out_valid is low has no effect.
- Reset mid-frame or mid-HOLD: all state is discarded immediately (asynchronous). No partial result is emitted.
- No sample can be accepted in the same cycle as the output handshake; in_ready is 0 in HOLD.

## Configuration
- K_ENERGY_ACC_SAT_EN defined:
  - Stage 3 saturates. If acc + sum > 2^OUT_WIDTH-1, acc = 2^OUT_WIDTH-1.
  - out_sat is set sticky for the rest of the frame.
- K_ENERGY_ACC_SAT_EN undefined:
  - acc wraps modulo 2^OUT_WIDTH.
  - out_sat is tied to 0.

## Test plan
- Basic frame (FRAME_LEN=4): inputs (3,4), (1,-1), (0,0), (-2,0) back-to-back → out_energy=31 and out_valid high 3 cycles after the 4th accept, out_sat=0.
- Input gaps (FRAME_LEN=4): same four samples, with in_valid low for 2 cycles between each → out_energy=31. Exactly 4 accepts occur.
- Back-pressure: after the frame completes, hold out_ready low for 10 cycles → out_energy and out_valid stay stable and in_ready=0. Raise out_ready for 1 cycle → out_valid=0 and in_ready=1 on the next cycle. A following frame of (1,0)x4 → 4.
- Saturation (IN_WIDTH=16, OUT_WIDTH=33, FRAME_LEN=4): send (-32768,-32768) four times, each bin = 2^31, true total 2^33.
  - With K_ENERGY_ACC_SAT_EN: out_energy = 2^33-1, out_sat=1.
  - Without it: out_energy = 0, out_sat=0.
- Reset mid-frame (FRAME_LEN=4): accept (5,5) twice, pulse rst asynchronously between edges → outputs and in_ready go to 0 immediately. Then accept (1,0)x4 → out_energy=4.
- FRAME_LEN=1: inputs (2,3) then (0,1) → two results, 13 then 1, each 3 cycles after its accept.
